// File: rtl/unpacked_stream_serializer_if.sv
// Bundled handshake signals for unpacked_stream_serializer: one wide input vector and a narrow output beat stream.
// data_out_last exists only when UNPACKED_STREAM_SERIALIZER_LAST_EN is defined.
interface unpacked_stream_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_SIZE    = 16,
  parameter int OUT_SIZE   = 4
);
  logic [DATA_WIDTH-1:0] data_in_data [IN_SIZE-1:0];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out_data [OUT_SIZE-1:0];
  logic                  data_out_valid;
  logic                  data_out_ready;
`ifdef UNPACKED_STREAM_SERIALIZER_LAST_EN
  logic                  data_out_last;

  // master is the surrounding system, slave is the serializer
  modport master (
    output data_in_data, data_in_valid, data_out_ready,
    input  data_in_ready, data_out_data, data_out_valid, data_out_last
  );
  modport slave (
    input  data_in_data, data_in_valid, data_out_ready,
    output data_in_ready, data_out_data, data_out_valid, data_out_last
  );
`else
  modport master (
    output data_in_data, data_in_valid, data_out_ready,
    input  data_in_ready, data_out_data, data_out_valid
  );
  modport slave (
    input  data_in_data, data_in_valid, data_out_ready,
    output data_in_ready, data_out_data, data_out_valid
  );
`endif
endinterface

// File: rtl/unpacked_stream_serializer.sv
// Splits an IN_SIZE-element unpacked vector into IN_SIZE/OUT_SIZE beats of OUT_SIZE elements, lowest index first.
// IN_SIZE must be a multiple of OUT_SIZE. Optional data_out_last port: define UNPACKED_STREAM_SERIALIZER_LAST_EN.
module unpacked_stream_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_SIZE    = 16,
  parameter int OUT_SIZE   = 4
) (
  input logic                        clk,
  input logic                        rst,
  unpacked_stream_serializer_if.slave bus
);
  localparam int NUM_BEATS = IN_SIZE / OUT_SIZE;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg;
  logic [BEAT_W-1:0]     beat_reg;
  // Stored beat-major so a beat is selected with a single index
  logic [DATA_WIDTH-1:0] buffer_reg [NUM_BEATS-1:0][OUT_SIZE-1:0];
  logic [DATA_WIDTH-1:0] in_split   [NUM_BEATS-1:0][OUT_SIZE-1:0];
  logic                  on_last_beat;
  logic                  in_fire;
  logic                  out_fire;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
      for (gj = 0; gj < OUT_SIZE; gj++) begin : g_elem
        assign in_split[gi][gj] = bus.data_in_data[gi*OUT_SIZE + gj];
      end
    end
  endgenerate

  assign on_last_beat       = (beat_reg == LAST_BEAT);
  // Accepting while the final beat leaves keeps the stream bubble-free
  assign bus.data_in_ready  = (state_reg == IDLE) | (on_last_beat & bus.data_out_ready);
  assign in_fire            = bus.data_in_valid & bus.data_in_ready;
  assign bus.data_out_valid = (state_reg == BUSY);
  assign out_fire           = bus.data_out_valid & bus.data_out_ready;
  assign bus.data_out_data  = buffer_reg[beat_reg];

`ifdef UNPACKED_STREAM_SERIALIZER_LAST_EN
  assign bus.data_out_last  = bus.data_out_valid & on_last_beat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_fire) begin
            state_reg <= BUSY;
            beat_reg  <= '0;
          end
        end
        BUSY: begin
          if (in_fire) begin
            beat_reg <= '0;
          end else if (out_fire) begin
            if (on_last_beat) begin
              state_reg <= IDLE;
              beat_reg  <= '0;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          beat_reg  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_reg <= '{default: '0};
    end else if (in_fire) begin
      buffer_reg <= in_split;
    end
  end
endmodule

// File: doc/unpacked_stream_serializer.md
# unpacked_stream_serializer

Downstream width-conversion stage that accepts a full unpacked vector of `IN_SIZE` elements in one valid/ready handshake and emits it as `IN_SIZE/OUT_SIZE` consecutive beats of `OUT_SIZE` elements. It sits after an unpacked register slice, so wide parallel results can feed narrower compute or output stages. Full-throughput: a new vector is accepted in the same cycle the final beat of the previous one leaves.

## Interface
- `DATA_WIDTH`, 32, width of one element.
- `IN_SIZE`, 16, elements per input vector.
- `OUT_SIZE`, 4, elements per output beat. `IN_SIZE % OUT_SIZE == 0` is required. `NUM_BEATS = IN_SIZE/OUT_SIZE`.

Reset rst, synchronous, active-high; clock clk.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `data_in_data`  in  `DATA_WIDTH` x `[IN_SIZE-1:0]`  input vector, unpacked.
- `data_in_valid`  in  1  input vector valid.
- `data_in_ready`  out  1  stage can accept a vector.
- `data_out_data`  out  `DATA_WIDTH` x `[OUT_SIZE-1:0]`  current beat, unpacked.
- `data_out_valid`  out  1  beat valid.
- `data_out_ready`  in  1  consumer accepts beat.
- `data_out_last`  out  1  current beat is beat `NUM_BEATS-1`. Present only with `UNPACKED_STREAM_SERIALIZER_LAST_EN`.

## Operation
- Storage: `buffer` (IN_SIZE elements), `beat` counter of width `max(1,$clog2(NUM_BEATS))`, and state `IDLE`/`BUSY`.
- Input accept: `in_fire = data_in_valid & data_in_ready`. On `in_fire`, the block captures `data_in_data` into `buffer`, sets `beat <= 0` and moves to `BUSY`. When there is no `in_fire`, `data_in_data` is ignored.
- Output: `data_out_valid = (state == BUSY)`. `data_out_data[j] = buffer[beat*OUT_SIZE + j]`, so beat 0 carries elements 0..OUT_SIZE-1 and the lowest index goes first.
- Output fire: `out_fire = data_out_valid & data_out_ready`.
  - If `beat < NUM_BEATS-1`, `beat` increments.
  - If it is the final beat and there is no `in_fire`, the state moves to `IDLE`.
- `data_in_ready = (state == IDLE) | (beat == NUM_BEATS-1 & data_out_ready)`. This is combinational from `data_out_ready`.
- Final-beat fire and `in_fire` in the same cycle: the state stays `BUSY`, `beat <= 0`, and `buffer` takes the new vector. There is no bubble.
- Backpressure: while `data_out_valid & !data_out_ready`, `data_out_data`, `beat` and `buffer` hold stable.
- Degenerate case `OUT_SIZE == IN_SIZE`: one beat per vector. The block then behaves as a full-throughput register stage.
- No arithmetic; data passes through unmodified.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state `IDLE`, `beat` 0, `buffer` 0;
  - `data_out_valid` 0, `data_out_data` all 0, `data_out_last` 0;
  - `data_in_ready` 1.
- `rst` asserted mid-vector discards the remaining beats. No further output appears until a new `in_fire`.
- Latency: beat 0 is valid on the cycle after `in_fire`.
- Throughput: one vector per `NUM_BEATS` cycles when `data_out_ready` is held high.
- `data_out_valid` never drops without `out_fire` (AXI-stream-style rule). `data_out_valid` and `data_out_data` are registered-derived, with no combinational path from input to output.

## Configuration
- `UNPACKED_STREAM_SERIALIZER_LAST_EN` defined:
  - the `data_out_last` port exists, `data_out_last = data_out_valid & (beat == NUM_BEATS-1)`;
  - the bench checks `data_out_last` on every beat.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults, vector with `element[i] = i`, `data_out_ready` = 1. Required response:
  - beats `{0,1,2,3}`, `{4,5,6,7}`, `{8,9,10,11}`, `{12,13,14,15}` on 4 consecutive cycles, starting 1 cycle after `in_fire`;
  - `data_out_last` high only on the 4th beat.
- Two vectors offered back-to-back (`0..15`, then `100..115`), ready held at 1. Required response:
  - 8 contiguous valid beats with no bubble;
  - the second vector is accepted in the cycle of beat 3 of the first.
- Random `data_out_ready` with 40% low. Required response:
  - beat data and valid hold while stalled;
  - the sequence is unchanged;
  - `data_in_ready` stays 0 on beats 0–2.
- `rst` pulsed for 1 cycle after beat 1 fires. Required response:
  - next cycle `data_out_valid` = 0 and `data_in_ready` = 1;
  - the next vector `200..215` is serialized from element 200.
- `OUT_SIZE` = 16 build. Required response: each vector is emitted as one beat the cycle after accept, at full throughput under continuous valid and ready.
- `data_in_data` toggled while `data_in_valid` is 0 or `data_in_ready` is 0. Required response: the output stream is unaffected.
